instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch stage of the multicycle RISC-V core. Holds the program counter, drives the word address into the instruction ROM, and waits out the ROM's one-cycle registered read latency. It then captures the returned word into the instruction register and hands it to the control FSM with a one-cycle valid pulse. It also handles PC redirects from branch/jump resolution, flags misaligned or out-of-range fetches, and counts completed fetches.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- ADDR_W, 14, ROM byte-address width; legal PCs are below 2**ADDR_W
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- i_fetch_req  in  1  control FSM requests the next instruction; sampled only in IDLE
- i_pc_we  in  1  PC redirect strobe (branch/jump/trap target)
- i_pc_next  in  32  redirect target, valid with i_pc_we
- o_rom_addr  out  ADDR_W  byte address to ROM, = pc[ADDR_W-1:0], combinational from PC register
- i_rom_data  in  32  ROM read data, registered inside ROM (valid one cycle after address)
- o_instr  out  32  instruction register
- o_instr_pc  out  32  PC of the word held in o_instr
- o_instr_valid  out  1  one-cycle pulse: o_instr/o_instr_pc just updated
- o_busy  out  1  high in ISSUE and CAPTURE
- o_fault  out  1  sticky: misaligned or out-of-range fetch attempted
- o_fetch_cnt  out  32  number of completed fetches, wraps

## Operation
- States: IDLE, ISSUE, CAPTURE, FAULT.
- IDLE:
  - i_pc_we=1: pc <= i_pc_next, regardless of i_fetch_req.
  - i_fetch_req=1: check the PC that will be used, i.e. i_pc_next if i_pc_we else pc.
  - If that PC has pc[1:0]!=0 or pc >= 2**ADDR_W: o_fault <= 1, go to FAULT, no fetch.
  - Otherwise go to ISSUE.
- ISSUE: o_rom_addr stable; the ROM registers the word at the closing edge. Go to CAPTURE.
- CAPTURE: i_rom_data valid. At the closing edge:
  - o_instr <= i_rom_data
  - o_instr_pc <= pc
  - pc <= pc + 4 (32-bit wrap)
  - o_instr_valid <= 1
  - o_fetch_cnt += 1
  - go to IDLE.
- i_pc_we in ISSUE or CAPTURE (flush): pc <= i_pc_next, in-flight fetch discarded. No o_instr_valid, no counter increment, o_instr/o_instr_pc unchanged, go to IDLE.
- FAULT: i_fetch_req ignored. i_pc_we loads pc, clears o_fault, and returns to IDLE. The fetch is not started in that cycle.
- o_busy = (state==ISSUE) | (state==CAPTURE).

## Timing
- Reset (async assert, sync release):
  - pc = RESET_PC
  - o_instr = 32'h0000_0013 (NOP)
  - o_instr_pc = 0
  - o_instr_valid = 0
  - o_fault = 0
  - o_fetch_cnt = 0
  - state = IDLE
  - o_rom_addr = RESET_PC[ADDR_W-1:0]
- Latency: i_fetch_req high in cycle N (IDLE) → ISSUE N+1 → CAPTURE N+2 → o_instr_valid high in cycle N+3, for exactly one cycle.
- Back-to-back: the earliest next request is cycle N+3, giving a 3-cycle fetch throughput.
- o_instr is held until the next successful capture.
- Reset asserted mid-fetch: immediate return to reset values; no valid pulse follows.
- o_fetch_cnt wraps 32'hFFFF_FFFF → 0.
- PC wrap 32'hFFFF_FFFC + 4 = 0 is not a fault.

## Test plan
- Reset then i_fetch_req pulse; ROM model returns 32'hff0100b7 at 0 → o_rom_addr=0, o_instr_valid at cycle 3, o_instr=32'hff0100b7, o_instr_pc=0, pc=4, o_fetch_cnt=1.
- Four requests issued as soon as IDLE is reached → addresses 0,4,8,0xC; valid pulses 3 cycles apart; o_fetch_cnt=4; o_busy low only in IDLE cycles.
- Redirect in IDLE with simultaneous request, i_pc_next=0x24 → o_rom_addr=0x24 in ISSUE, o_instr_pc=0x24, then pc=0x28.
- Redirect in CAPTURE to 0x100 → no valid pulse, o_instr unchanged, count unchanged, pc=0x100, IDLE next cycle.
- Request with pc=0x102 (misaligned) and with pc=0x4000 (ADDR_W=14) → o_fault=1, no ROM access, requests ignored. Redirect to 0x0 → o_fault=0, IDLE; next request fetches 0x0.
- rst_n asserted during ISSUE → all outputs at reset values in the same cycle; no valid pulse after release.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit_if
// Description : Control, redirect, ROM and instruction-output signals of the
//               instruction fetch stage, bundled for the fetch unit port.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 14
);
    logic              i_fetch_req;
    logic              i_pc_we;
    logic [31:0]       i_pc_next;
    logic [ADDR_W-1:0] o_rom_addr;
    logic [31:0]       i_rom_data;
    logic [31:0]       o_instr;
    logic [31:0]       o_instr_pc;
    logic              o_instr_valid;
    logic              o_busy;
    logic              o_fault;
    logic [31:0]       o_fetch_cnt;

    // Fetch unit side
    modport slave (
        input  i_fetch_req, i_pc_we, i_pc_next, i_rom_data,
        output o_rom_addr, o_instr, o_instr_pc, o_instr_valid,
               o_busy, o_fault, o_fetch_cnt
    );

    // Control FSM / ROM / environment side
    modport master (
        output i_fetch_req, i_pc_we, i_pc_next, i_rom_data,
        input  o_rom_addr, o_instr, o_instr_pc, o_instr_valid,
               o_busy, o_fault, o_fetch_cnt
    );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Multicycle fetch stage. Holds the PC, addresses a ROM with a
//               one-cycle registered read, captures the word into the
//               instruction register, handles redirects/flushes, flags
//               misaligned or out-of-range fetches and counts fetches.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 14
) (
    input  wire               clk,
    input  wire               rst_n,
    instr_fetch_unit_if.slave bus
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        FAULT   = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [31:0] check_pc;
    logic        check_bad;
    logic        pc_load;
    logic        capture;
    logic        fault_set;
    logic        fault_clr;

    // A request in IDLE is validated against the PC it will actually use,
    // which is the redirect target when a redirect arrives in the same cycle.
    assign check_pc  = bus.i_pc_we ? bus.i_pc_next : pc;
    assign check_bad = (check_pc[1:0] != 2'b00) || (|check_pc[31:ADDR_W]);

    assign bus.o_rom_addr = pc[ADDR_W-1:0];
    assign bus.o_busy     = (state == ISSUE) || (state == CAPTURE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath control; a redirect in ISSUE/CAPTURE flushes
    // the in-flight fetch instead of capturing it.
    always_comb begin
        state_nxt = state;
        pc_load   = 1'b0;
        capture   = 1'b0;
        fault_set = 1'b0;
        fault_clr = 1'b0;
        case (state)
            IDLE: begin
                pc_load = bus.i_pc_we;
                if (bus.i_fetch_req) begin
                    if (check_bad) begin
                        fault_set = 1'b1;
                        state_nxt = FAULT;
                    end else begin
                        state_nxt = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (bus.i_pc_we) begin
                    pc_load   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                state_nxt = IDLE;
                if (bus.i_pc_we) begin
                    pc_load = 1'b1;
                end else begin
                    capture = 1'b1;
                end
            end
            FAULT: begin
                if (bus.i_pc_we) begin
                    pc_load   = 1'b1;
                    fault_clr = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // PC, instruction register, valid pulse, fault flag and fetch counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc                <= RESET_PC;
            bus.o_instr       <= NOP;
            bus.o_instr_pc    <= 32'h0000_0000;
            bus.o_instr_valid <= 1'b0;
            bus.o_fault       <= 1'b0;
            bus.o_fetch_cnt   <= 32'h0000_0000;
        end else begin
            bus.o_instr_valid <= capture;
            if (pc_load) begin
                pc <= bus.i_pc_next;
            end else if (capture) begin
                pc <= pc + 32'd4;
            end
            if (capture) begin
                bus.o_instr     <= bus.i_rom_data;
                bus.o_instr_pc  <= pc;
                bus.o_fetch_cnt <= bus.o_fetch_cnt + 32'd1;
            end
            if (fault_set) begin
                bus.o_fault <= 1'b1;
            end else if (fault_clr) begin
                bus.o_fault <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Directed self-checking bench for instr_fetch_unit with a
//               registered-read ROM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    instr_fetch_unit_if #(.ADDR_W(14)) bus ();

    instr_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .ADDR_W   (14)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM contents: word 0 is a fixed LUI, every other word encodes its address
    function automatic logic [31:0] rom_word(input logic [13:0] a);
        if (a == 14'd0) return 32'hff01_00b7;
        return 32'hA500_0000 | {18'd0, a};
    endfunction

    // ROM with one-cycle registered read
    always @(posedge clk) bus.i_rom_data <= rom_word(bus.o_rom_addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rom_addr"}, 32'(bus.o_rom_addr), 32'h0);
        chk({tag, "_instr"},    bus.o_instr,         32'h0000_0013);
        chk({tag, "_instr_pc"}, bus.o_instr_pc,      32'h0);
        chk({tag, "_valid"},    32'(bus.o_instr_valid), 32'h0);
        chk({tag, "_fault"},    32'(bus.o_fault),    32'h0);
        chk({tag, "_cnt"},      bus.o_fetch_cnt,     32'h0);
        chk({tag, "_busy"},     32'(bus.o_busy),     32'h0);
    endtask

    // Issue a request this cycle, check ISSUE/CAPTURE/valid timing and results
    task automatic fetch(input string tag, input logic [31:0] exp_pc,
                         input logic [31:0] exp_instr, input logic [31:0] exp_cnt);
        bus.i_fetch_req = 1'b1;
        tick();
        bus.i_fetch_req = 1'b0;
        bus.i_pc_we     = 1'b0;
        chk({tag, "_issue_busy"}, 32'(bus.o_busy), 32'h1);
        chk({tag, "_issue_addr"}, 32'(bus.o_rom_addr), exp_pc);
        tick();
        chk({tag, "_cap_busy"},   32'(bus.o_busy), 32'h1);
        chk({tag, "_cap_valid"},  32'(bus.o_instr_valid), 32'h0);
        tick();
        chk({tag, "_valid"},      32'(bus.o_instr_valid), 32'h1);
        chk({tag, "_busy_idle"},  32'(bus.o_busy), 32'h0);
        chk({tag, "_instr"},      bus.o_instr, exp_instr);
        chk({tag, "_instr_pc"},   bus.o_instr_pc, exp_pc);
        chk({tag, "_next_addr"},  32'(bus.o_rom_addr), exp_pc + 32'd4);
        chk({tag, "_cnt"},        bus.o_fetch_cnt, exp_cnt);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.i_fetch_req = 1'b0;
        bus.i_pc_we     = 1'b0;
        bus.i_pc_next   = 32'h0;

        // Reset values
        tick();
        tick();
        chk_reset_vals("rst");
        rst_n = 1'b1;
        tick();
        chk_reset_vals("post_rst");

        // First fetch at address 0
        fetch("f0", 32'h0, 32'hff01_00b7, 32'd1);
        tick();
        chk("f0_pulse_one_cycle", 32'(bus.o_instr_valid), 32'h0);
        chk("f0_instr_held", bus.o_instr, 32'hff01_00b7);

        // Back-to-back fetches, each requested on the first IDLE cycle
        fetch("b1", 32'h4,  32'hA500_0004, 32'd2);
        fetch("b2", 32'h8,  32'hA500_0008, 32'd3);
        fetch("b3", 32'hC,  32'hA500_000C, 32'd4);
        fetch("b4", 32'h10, 32'hA500_0010, 32'd5);

        // Redirect in IDLE together with a request
        bus.i_pc_we   = 1'b1;
        bus.i_pc_next = 32'h24;
        fetch("redir", 32'h24, 32'hA500_0024, 32'd6);

        // Redirect during CAPTURE flushes the fetch
        bus.i_fetch_req = 1'b1;
        tick();
        bus.i_fetch_req = 1'b0;
        tick();
        chk("flush_in_capture", 32'(bus.o_busy), 32'h1);
        bus.i_pc_we   = 1'b1;
        bus.i_pc_next = 32'h100;
        tick();
        bus.i_pc_we = 1'b0;
        chk("flush_valid",    32'(bus.o_instr_valid), 32'h0);
        chk("flush_instr",    bus.o_instr, 32'hA500_0024);
        chk("flush_instr_pc", bus.o_instr_pc, 32'h24);
        chk("flush_cnt",      bus.o_fetch_cnt, 32'd6);
        chk("flush_addr",     32'(bus.o_rom_addr), 32'h100);
        chk("flush_idle",     32'(bus.o_busy), 32'h0);
        tick();
        chk("flush_no_late_valid", 32'(bus.o_instr_valid), 32'h0);

        // Misaligned fetch
        bus.i_pc_we     = 1'b1;
        bus.i_pc_next   = 32'h102;
        bus.i_fetch_req = 1'b1;
        tick();
        bus.i_pc_we = 1'b0;
        chk("mis_fault", 32'(bus.o_fault), 32'h1);
        chk("mis_busy",  32'(bus.o_busy), 32'h0);
        tick();
        tick();
        chk("mis_req_ignored_busy",  32'(bus.o_busy), 32'h0);
        chk("mis_req_ignored_valid", 32'(bus.o_instr_valid), 32'h0);
        chk("mis_fault_sticky",      32'(bus.o_fault), 32'h1);
        chk("mis_cnt",               bus.o_fetch_cnt, 32'd6);

        // Leave FAULT via redirect to an out-of-range target, then request it
        bus.i_fetch_req = 1'b0;
        bus.i_pc_we     = 1'b1;
        bus.i_pc_next   = 32'h4000;
        tick();
        bus.i_pc_we = 1'b0;
        chk("oor_clear", 32'(bus.o_fault), 32'h0);
        bus.i_fetch_req = 1'b1;
        tick();
        bus.i_fetch_req = 1'b0;
        chk("oor_fault", 32'(bus.o_fault), 32'h1);
        chk("oor_busy",  32'(bus.o_busy), 32'h0);

        // Redirect to 0 with a request: fault clears, fetch not started
        bus.i_pc_we     = 1'b1;
        bus.i_pc_next   = 32'h0;
        bus.i_fetch_req = 1'b1;
        tick();
        bus.i_pc_we     = 1'b0;
        bus.i_fetch_req = 1'b0;
        chk("recover_fault", 32'(bus.o_fault), 32'h0);
        chk("recover_idle",  32'(bus.o_busy), 32'h0);
        chk("recover_addr",  32'(bus.o_rom_addr), 32'h0);
        fetch("recover", 32'h0, 32'hff01_00b7, 32'd7);

        // Reset asserted during ISSUE
        bus.i_fetch_req = 1'b1;
        tick();
        bus.i_fetch_req = 1'b0;
        chk("arst_in_issue", 32'(bus.o_busy), 32'h1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("arst");
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("arst_no_valid", 32'(bus.o_instr_valid), 32'h0);
        end
        chk("arst_cnt_after", bus.o_fetch_cnt, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
